// File: rtl/arcade_wrapper.sv
// Two-player reaction arcade top: 8N1 UART config receiver, button conditioning
// and the game state machine, all driving registered pin-level outputs.
module arcade_wrapper #(
  parameter int unsigned CLK_HZ         = 50000000,
  parameter int unsigned BIT_RATE       = 9600,
  parameter int unsigned DELAY_CYCLES   = 200,
  parameter int unsigned BUZZ_CYCLES    = 100,
  parameter int unsigned DEFAULT_TARGET = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rxd,
  input  logic        uart_rx_en,
  output logic        uart_rx_break,
  output logic        uart_rx_valid,
  output logic [7:0]  uart_rx_data,
  input  logic [2:0]  input_gpio_pins,
  output logic [11:0] output_gpio_pins,
  output logic        write_done,
  output logic [2:0]  instructions,
  output logic        buzzer
);

  localparam int unsigned ClksPerBit = CLK_HZ / BIT_RATE;
  localparam int unsigned HalfBit    = ClksPerBit / 2;
  localparam int unsigned CntW       = $clog2(ClksPerBit + 1);
  localparam int unsigned DlyW       = $clog2(DELAY_CYCLES + 1);
  localparam int unsigned BzW        = $clog2(BUZZ_CYCLES + 1);

  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StWait  = 3'd1,
    StGo    = 3'd2,
    StScore = 3'd3,
    StOver  = 3'd4
  } game_state_e;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  // Input conditioning
  logic       rxd_meta_q, rxd_sync_q, rxd_prev_q;
  logic [2:0] btn_meta_q, btn_sync_q, btn_prev_q, btn_evt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      rxd_prev_q <= 1'b1;
      btn_meta_q <= '0;
      btn_sync_q <= '0;
      btn_prev_q <= '0;
      btn_evt_q  <= '0;
    end else begin
      rxd_meta_q <= uart_rxd;
      rxd_sync_q <= rxd_meta_q;
      rxd_prev_q <= rxd_sync_q;
      btn_meta_q <= input_gpio_pins;
      btn_sync_q <= btn_meta_q;
      btn_prev_q <= btn_sync_q;
      btn_evt_q  <= btn_sync_q & ~btn_prev_q;
    end
  end

  logic start_e, p1_e, p2_e;
  assign p1_e    = btn_evt_q[0];
  assign p2_e    = btn_evt_q[1];
  assign start_e = btn_evt_q[2];

  // UART receiver
  rx_state_e       rx_state_q, rx_state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d, rx_data_d;
  logic            rx_valid_d, rx_break_d;

  always_comb begin
    rx_state_d = rx_state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    rx_data_d  = uart_rx_data;
    rx_valid_d = 1'b0;
    rx_break_d = 1'b0;
    if (!uart_rx_en) begin
      rx_state_d = RxIdle;
    end else begin
      case (rx_state_q)
        RxIdle: begin
          if (rxd_prev_q && !rxd_sync_q) begin
            rx_state_d = RxStart;
            cnt_d      = '0;
          end
        end
        RxStart: begin
          if (cnt_q == CntW'(HalfBit - 1)) begin
            cnt_d      = '0;
            bit_d      = '0;
            // Line back high at mid start bit: treat as a glitch
            rx_state_d = rxd_sync_q ? RxIdle : RxData;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        RxData: begin
          if (cnt_q == CntW'(ClksPerBit - 1)) begin
            cnt_d   = '0;
            shift_d = {rxd_sync_q, shift_q[7:1]};
            if (bit_q == 3'd7) rx_state_d = RxStop;
            else               bit_d      = bit_q + 3'd1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        RxStop: begin
          if (cnt_q == CntW'(ClksPerBit - 1)) begin
            rx_state_d = RxIdle;
            if (rxd_sync_q) begin
              rx_data_d  = shift_q;
              rx_valid_d = 1'b1;
            end else if (shift_q == 8'h00) begin
              rx_break_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: rx_state_d = RxIdle;
      endcase
    end
  end

  // Configuration
  logic       loaded_q, loaded_d;
  logic [3:0] target_q, target_d;

  always_comb begin
    loaded_d = loaded_q;
    target_d = target_q;
    if (uart_rx_valid && !loaded_q) begin
      loaded_d = 1'b1;
      target_d = (uart_rx_data[3:0] == 4'd0) ? 4'(DEFAULT_TARGET) : uart_rx_data[3:0];
    end
  end

  // Game FSM
  game_state_e     state_q, state_d;
  logic [DlyW-1:0] dly_q, dly_d;
  logic [BzW-1:0]  bz_q, bz_d;
  logic [3:0]      p1_q, p1_d, p2_q, p2_d;
  logic            win1_d, win2_d;

  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    bz_d    = bz_q;
    p1_d    = p1_q;
    p2_d    = p2_q;
    case (state_q)
      StIdle: begin
        if (write_done && start_e) begin
          state_d = StWait;
          dly_d   = DlyW'(DELAY_CYCLES);
        end
      end
      StWait: begin
        if (write_done) begin
          if (p1_e && p2_e) begin
            dly_d = DlyW'(DELAY_CYCLES);
          end else if (p1_e || p2_e) begin
            // Early press is a foul: the opponent scores
            if (p1_e) p2_d = sat_inc(p2_q);
            else      p1_d = sat_inc(p1_q);
            state_d = StScore;
            bz_d    = BzW'(BUZZ_CYCLES - 1);
          end else if (dly_q == '0) begin
            state_d = StGo;
          end else begin
            dly_d = dly_q - 1'b1;
          end
        end
      end
      StGo: begin
        if (write_done) begin
          if (p1_e && p2_e) begin
            state_d = StWait;
            dly_d   = DlyW'(DELAY_CYCLES);
          end else if (p1_e || p2_e) begin
            if (p1_e) p1_d = sat_inc(p1_q);
            else      p2_d = sat_inc(p2_q);
            state_d = StScore;
            bz_d    = BzW'(BUZZ_CYCLES - 1);
          end
        end
      end
      StScore: begin
        if (write_done) begin
          if (bz_q == '0) begin
            if (p1_q == target_q || p2_q == target_q) begin
              state_d = StOver;
            end else begin
              state_d = StWait;
              dly_d   = DlyW'(DELAY_CYCLES);
            end
          end else begin
            bz_d = bz_q - 1'b1;
          end
        end
      end
      StOver: begin
        if (write_done && start_e) begin
          p1_d    = '0;
          p2_d    = '0;
          state_d = StWait;
          dly_d   = DlyW'(DELAY_CYCLES);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign win1_d = (state_d == StOver) && (p1_d == target_q);
  assign win2_d = (state_d == StOver) && (p2_d == target_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_q       <= RxIdle;
      cnt_q            <= '0;
      bit_q            <= '0;
      shift_q          <= '0;
      uart_rx_data     <= '0;
      uart_rx_valid    <= 1'b0;
      uart_rx_break    <= 1'b0;
      loaded_q         <= 1'b0;
      target_q         <= 4'(DEFAULT_TARGET);
      write_done       <= 1'b0;
      state_q          <= StIdle;
      dly_q            <= '0;
      bz_q             <= '0;
      p1_q             <= '0;
      p2_q             <= '0;
      instructions     <= '0;
      buzzer           <= 1'b0;
      output_gpio_pins <= '0;
    end else begin
      rx_state_q       <= rx_state_d;
      cnt_q            <= cnt_d;
      bit_q            <= bit_d;
      shift_q          <= shift_d;
      uart_rx_data     <= rx_data_d;
      uart_rx_valid    <= rx_valid_d;
      uart_rx_break    <= rx_break_d;
      loaded_q         <= loaded_d;
      target_q         <= target_d;
      write_done       <= loaded_q | ~uart_rx_en;
      state_q          <= state_d;
      dly_q            <= dly_d;
      bz_q             <= bz_d;
      p1_q             <= p1_d;
      p2_q             <= p2_d;
      instructions     <= state_d;
      buzzer           <= (state_d == StScore);
      output_gpio_pins <= {(state_d == StOver), win2_d, win1_d, (state_d == StGo), p2_d, p1_d};
    end
  end

endmodule

// File: tb/tb_arcade_wrapper.sv
// Randomized bench for arcade_wrapper: a round-level model of the game rules
// predicts scores, state codes, buzzer length and UART configuration results.
module tb_arcade_wrapper;

  localparam int unsigned ClkHz  = 153600;
  localparam int unsigned BitRate = 9600;
  localparam int unsigned Cpb    = ClkHz / BitRate;
  localparam int unsigned Delay  = 200;
  localparam int unsigned Buzz   = 100;
  localparam int unsigned DefTgt = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        uart_rxd = 1'b1;
  logic        uart_rx_en = 1'b0;
  logic [2:0]  pins = 3'b000;
  logic        uart_rx_break, uart_rx_valid, write_done, buzzer;
  logic [7:0]  uart_rx_data;
  logic [11:0] gpio;
  logic [2:0]  instructions;

  int total = 0;
  int bad = 0;
  int valid_cnt = 0;
  int break_cnt = 0;
  int m_p1, m_p2, m_tgt;

  arcade_wrapper #(
    .CLK_HZ(ClkHz),
    .BIT_RATE(BitRate),
    .DELAY_CYCLES(Delay),
    .BUZZ_CYCLES(Buzz),
    .DEFAULT_TARGET(DefTgt)
  ) dut (
    .clk(clk),
    .rst(rst),
    .uart_rxd(uart_rxd),
    .uart_rx_en(uart_rx_en),
    .uart_rx_break(uart_rx_break),
    .uart_rx_valid(uart_rx_valid),
    .uart_rx_data(uart_rx_data),
    .input_gpio_pins(pins),
    .output_gpio_pins(gpio),
    .write_done(write_done),
    .instructions(instructions),
    .buzzer(buzzer)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (uart_rx_valid === 1'b1) valid_cnt++;
    if (uart_rx_break === 1'b1) break_cnt++;
  end

  initial begin
    #950000;
    $display("FAIL watchdog: got=still running exp=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= 15) ? 15 : v + 1;
  endfunction

  function automatic logic [26:0] all_outs();
    return {uart_rx_break, uart_rx_valid, uart_rx_data, gpio, write_done, instructions, buzzer};
  endfunction

  task automatic press(input logic [2:0] m);
    pins = m;
    @(negedge clk);
    pins = 3'b000;
  endtask

  task automatic wait_state(input logic [2:0] exp, input int budget, input string tag,
                            output int n);
    n = 0;
    while (instructions !== exp && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, instructions, exp);
  endtask

  task automatic check_scores(input string tag);
    check_eq({tag, "_p1"}, gpio[3:0], m_p1);
    check_eq({tag, "_p2"}, gpio[7:4], m_p2);
  endtask

  task automatic finish_score();
    int n, g, exp_st;
    wait_state(3'd3, 20, "score_entry", n);
    n = 0;
    g = 0;
    while (instructions == 3'd3 && g < Buzz + 20) begin
      if (buzzer) n++;
      g++;
      @(negedge clk);
    end
    check_eq("buzz_len", n, Buzz);
    check_eq("buzz_off", buzzer, 1'b0);
    check_scores("score");
    exp_st = (m_p1 == m_tgt || m_p2 == m_tgt) ? 4 : 1;
    check_eq("after_score", instructions, exp_st);
    if (exp_st == 4)
      check_eq("win_bits", gpio[11:9], {1'b1, m_p2 == m_tgt, m_p1 == m_tgt});
  endtask

  // Entered at the first cycle of WAIT. 0/1: P1/P2 wins in GO, 2: foul, 3: tie in GO.
  task automatic play_round(input int kind);
    int n, g, who;
    case (kind)
      0, 1: begin
        wait_state(3'd2, Delay + 20, "go_entry", n);
        check_eq("go_lamp", gpio[8], 1'b1);
        press(kind == 0 ? 3'b001 : 3'b010);
        if (kind == 0) m_p1 = sat(m_p1);
        else           m_p2 = sat(m_p2);
        finish_score();
      end
      2: begin
        who = $urandom_range(0, 1);
        press(who == 0 ? 3'b001 : 3'b010);
        if (who == 0) m_p2 = sat(m_p2);
        else          m_p1 = sat(m_p1);
        finish_score();
      end
      default: begin
        wait_state(3'd2, Delay + 20, "tie_go", n);
        press(3'b011);
        g = 0;
        while (instructions == 3'd2 && g < 20) begin
          @(negedge clk);
          g++;
        end
        check_eq("tie_state", instructions, 3'd1);
        check_scores("tie");
      end
    endcase
  endtask

  task automatic play_to_over(input string tag);
    int r = 0;
    while (instructions == 3'd1 && r < 80) begin
      play_round($urandom_range(0, 3));
      r++;
    end
    check_eq(tag, instructions, 3'd4);
  endtask

  task automatic do_reset(input logic en);
    @(negedge clk);
    rst = 1'b1;
    pins = 3'b000;
    uart_rxd = 1'b1;
    uart_rx_en = en;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    m_p1 = 0;
    m_p2 = 0;
    m_tgt = DefTgt;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    uart_rxd = 1'b0;
    repeat (Cpb) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = d[i];
      repeat (Cpb) @(negedge clk);
    end
    uart_rxd = stop;
    repeat (Cpb) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (2 * Cpb) @(negedge clk);
  endtask

  initial begin
    int n, v0, b0;
    logic [7:0] b;

    // Reset held with buttons toggling
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      pins = 3'($urandom);
      if (i % 50 == 49) check_eq("rst_hold", all_outs(), 0);
    end
    pins = 3'b000;
    rst = 1'b0;
    m_p1 = 0;
    m_p2 = 0;
    m_tgt = DefTgt;
    check_eq("wd_at_release", write_done, 1'b0);
    @(negedge clk);
    check_eq("wd_default", write_done, 1'b1);

    // Default run: start, WAIT length, P1 point, P1 foul, tie, then to OVER
    press(3'b100);
    wait_state(3'd1, 20, "start", n);
    wait_state(3'd2, Delay + 20, "go_first", n);
    check_eq("wait_len", (n >= Delay && n <= Delay + 2), 1);
    press(3'b001);
    m_p1 = 1;
    finish_score();
    press(3'b001);
    m_p2 = sat(m_p2);
    finish_score();
    play_round(3);
    play_to_over("default_over");

    // Restart from OVER
    press(3'b100);
    wait_state(3'd1, 20, "restart", n);
    m_p1 = 0;
    m_p2 = 0;
    check_scores("restart");
    check_eq("restart_win", gpio[11:9], 3'b000);

    // Asynchronous reset between clock edges
    @(negedge clk);
    #2 rst = 1'b1;
    uart_rx_en = 1'b1;
    #1 check_eq("async_rst", all_outs(), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_p1 = 0;
    m_p2 = 0;
    m_tgt = DefTgt;

    // UART configuration: target 3, FSM held until loaded
    repeat (5) @(negedge clk);
    check_eq("wd_unloaded", write_done, 1'b0);
    press(3'b100);
    repeat (8) @(negedge clk);
    check_eq("held_idle", instructions, 3'd0);
    v0 = valid_cnt;
    b0 = break_cnt;
    send_frame(8'h03, 1'b1);
    check_eq("cfg_valid", valid_cnt - v0, 1);
    check_eq("cfg_break", break_cnt - b0, 0);
    check_eq("cfg_data", uart_rx_data, 8'h03);
    check_eq("cfg_wd", write_done, 1'b1);
    m_tgt = 3;
    send_frame(8'h07, 1'b1);
    check_eq("second_data", uart_rx_data, 8'h07);
    press(3'b100);
    wait_state(3'd1, 20, "cfg_start", n);
    for (int i = 0; i < 3; i++) play_round(1);
    check_eq("p2_wins", gpio[11:9], 3'b110);
    check_eq("p2_over", instructions, 3'd4);

    // BREAK, framing error, start glitch, then random configuration
    do_reset(1'b1);
    v0 = valid_cnt;
    b0 = break_cnt;
    send_frame(8'h00, 1'b0);
    check_eq("brk_pulse", break_cnt - b0, 1);
    check_eq("brk_valid", valid_cnt - v0, 0);
    check_eq("brk_wd", write_done, 1'b0);
    check_eq("brk_data", uart_rx_data, 8'h00);
    send_frame(8'hA5, 1'b0);
    uart_rxd = 1'b0;
    repeat (2) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (3 * Cpb) @(negedge clk);
    check_eq("ferr_glitch_valid", valid_cnt - v0, 0);
    check_eq("ferr_glitch_break", break_cnt - b0, 1);
    check_eq("ferr_wd", write_done, 1'b0);
    b = 8'($urandom);
    send_frame(b, 1'b1);
    m_tgt = (b[3:0] == 4'd0) ? DefTgt : int'(b[3:0]);
    check_eq("rand_data", uart_rx_data, b);
    check_eq("rand_wd", write_done, 1'b1);
    press(3'b100);
    wait_state(3'd1, 20, "rand_start", n);
    play_to_over("rand_over");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
